// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared definitions for the memory bus controller: FSM state
//                encoding, region index constants and the byte-lane shift
//                helper used for store alignment and load extraction.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_FAULT  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Region indices into the one-hot select / ack vectors
   localparam int REGION_ROM  = 0;
   localparam int REGION_RAM  = 1;
   localparam int REGION_IO   = 2;
   localparam int NUM_REGIONS = 3;

   // Byte lane geometry: a lane is 8 bits, so a lane offset becomes a bit
   // shift by multiplying with 2**LANE_SHIFT.
   localparam int LANE_BITS  = 8;
   localparam int LANE_SHIFT = $clog2(LANE_BITS);

   // Bit shift amount for a given byte-lane offset (0, 8, 16 or 24)
   function automatic logic [4:0] lane_amount(input logic [1:0] off);
      return 5'(off) << LANE_SHIFT;
   endfunction

endpackage : mem_bus_pkg
`default_nettype wire

// File: rtl/mem_bus_region_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_region_decoder
//  Description : Combinational address decoder. Matches the address against
//                the ROM, RAM and IO windows (base-aligned, power-of-two size)
//                and flags accesses that must fault without touching the bus.
//  Ports       : addr     - CPU byte address
//                is_write - access is a store
//                hit      - one-hot region hit (0 ROM, 1 RAM, 2 IO)
//                illegal  - unmapped address, or a store into ROM
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_region_decoder
   import mem_bus_pkg::*;
#(
   parameter logic [31:0] ROM_BASE      = 32'h0000_0000,
   parameter int          ROM_SIZE_BITS = 14,
   parameter logic [31:0] RAM_BASE      = 32'h4000_0000,
   parameter int          RAM_SIZE_BITS = 16,
   parameter logic [31:0] IO_BASE       = 32'h8000_0000,
   parameter int          IO_SIZE_BITS  = 12
) (
   input  logic [31:0]            addr,
   input  logic                   is_write,
   output logic [NUM_REGIONS-1:0] hit,
   output logic                   illegal
);

   // A region hits when every address bit above its size exponent equals the
   // base: XOR with the base, then discard the in-region offset bits.
   always_comb begin
      hit             = '0;
      hit[REGION_ROM] = ((addr ^ ROM_BASE) >> ROM_SIZE_BITS) == 32'd0;
      hit[REGION_RAM] = ((addr ^ RAM_BASE) >> RAM_SIZE_BITS) == 32'd0;
      hit[REGION_IO]  = ((addr ^ IO_BASE)  >> IO_SIZE_BITS)  == 32'd0;
   end

   assign illegal = ~(|hit) | (is_write & hit[REGION_ROM]);

endmodule : mem_bus_region_decoder
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_ctrl
//  Description : Memory-side controller behind the CPU ma_* access port.
//                Accepts one read/write at a time, decodes it into ROM, RAM
//                or IO, drives the lane-aligned word bus and returns a
//                one-cycle completion pulse. Unmapped addresses, ROM stores
//                and missing acknowledges complete with ma_timeout set.
//  Ports       : clk, rst                  - clock, sync active-high reset
//                ma_addr/ma_data_out/mask  - CPU request address/data/lanes
//                ma_rd_req, ma_wr_req      - request levels (read wins)
//                ma_data_in                - load data shifted to bit 0
//                ma_done, ma_timeout       - completion pulse and fault flag
//                bus_sel/bus_rd/bus_wr     - region select and slave strobes
//                bus_addr/bus_wdata/bus_be - word address, store data, lanes
//                bus_rdata0..2, bus_ack    - per-region read data and ack
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
   parameter int          ROM_SIZE_BITS  = 14,
   parameter logic [31:0] RAM_BASE       = 32'h4000_0000,
   parameter int          RAM_SIZE_BITS  = 16,
   parameter logic [31:0] IO_BASE        = 32'h8000_0000,
   parameter int          IO_SIZE_BITS   = 12,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ma_addr,
   input  logic [31:0] ma_data_out,
   input  logic [3:0]  ma_data_mask,
   input  logic        ma_rd_req,
   input  logic        ma_wr_req,
   output logic [31:0] ma_data_in,
   output logic        ma_done,
   output logic        ma_timeout,
   output logic [2:0]  bus_sel,
   output logic        bus_rd,
   output logic        bus_wr,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic [31:0] bus_rdata0,
   input  logic [31:0] bus_rdata1,
   input  logic [31:0] bus_rdata2,
   input  logic [2:0]  bus_ack
);

   // Counter value seen during the last ACCESS cycle allowed before timeout
   localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t                   r_state;
   state_t                   w_next;

   logic [NUM_REGIONS-1:0]   r_sel;
   logic                     r_rd;
   logic                     r_wr;
   logic [31:0]              r_addr;
   logic [31:0]              r_wdata;
   logic [3:0]               r_be;
   logic [1:0]               r_offset;
   logic [7:0]               r_count;
   logic [31:0]              r_data_in;
   logic                     r_done;
   logic                     r_timeout;

   logic                     w_req;
   logic                     w_is_read;
   logic [NUM_REGIONS-1:0]   w_hit;
   logic                     w_illegal;
   logic                     w_ack;
   logic                     w_count_last;
   logic [31:0]              w_rdata_sel;
   logic [31:0]              w_rdata_shifted;
   logic [31:0]              w_wdata_shifted;
   logic [3:0]               w_be_shifted;

   // ------------------------------------------------------------------
   // Request decode (only consumed in IDLE)
   // ------------------------------------------------------------------
   assign w_req     = ma_rd_req | ma_wr_req;
   assign w_is_read = ma_rd_req;

   mem_bus_region_decoder #(
      .ROM_BASE      (ROM_BASE),
      .ROM_SIZE_BITS (ROM_SIZE_BITS),
      .RAM_BASE      (RAM_BASE),
      .RAM_SIZE_BITS (RAM_SIZE_BITS),
      .IO_BASE       (IO_BASE),
      .IO_SIZE_BITS  (IO_SIZE_BITS)
   ) u_decoder (
      .addr     (ma_addr),
      .is_write (~w_is_read),
      .hit      (w_hit),
      .illegal  (w_illegal)
   );

   // Store data and enables move up to the addressed lane; anything pushed
   // beyond lane 3 falls off the word.
   assign w_wdata_shifted = ma_data_out << lane_amount(ma_addr[1:0]);
   assign w_be_shifted    = ma_data_mask << ma_addr[1:0];

   // ------------------------------------------------------------------
   // Slave response: only the selected region's ack and data matter
   // ------------------------------------------------------------------
   assign w_ack        = |(bus_ack & r_sel);
   assign w_count_last = (r_count == c_TIMEOUT_LAST);

   always_comb begin
      w_rdata_sel = ({32{r_sel[REGION_ROM]}} & bus_rdata0)
                  | ({32{r_sel[REGION_RAM]}} & bus_rdata1)
                  | ({32{r_sel[REGION_IO]}}  & bus_rdata2);
   end

   assign w_rdata_shifted = w_rdata_sel >> lane_amount(r_offset);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic. Ack wins over the timeout limit on the same
   // cycle, since both simply lead to DONE and the datapath decides which.
   // ------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               w_next = w_illegal ? ST_FAULT : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (w_ack || w_count_last) begin
               w_next = ST_DONE;
            end
         end
         ST_FAULT: w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Registered datapath and outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel     <= '0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_be      <= '0;
         r_offset  <= '0;
         r_count   <= '0;
         r_data_in <= '0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_done    <= (w_next == ST_DONE);
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_req && !w_illegal) begin
                  r_sel    <= w_hit;
                  r_rd     <= w_is_read;
                  r_wr     <= ~w_is_read;
                  r_addr   <= {ma_addr[31:2], 2'b00};
                  r_wdata  <= w_wdata_shifted;
                  r_be     <= w_be_shifted;
                  r_offset <= ma_addr[1:0];
                  r_count  <= '0;
               end
            end
            ST_ACCESS: begin
               r_count <= r_count + 8'd1;
               if (w_ack) begin
                  if (r_rd) begin
                     r_data_in <= w_rdata_shifted;
                  end
               end else if (w_count_last) begin
                  r_timeout <= 1'b1;
               end
               // Strobes and select drop on entry to DONE
               if (w_ack || w_count_last) begin
                  r_sel <= '0;
                  r_rd  <= 1'b0;
                  r_wr  <= 1'b0;
               end
            end
            ST_FAULT: begin
               r_timeout <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign ma_data_in = r_data_in;
   assign ma_done    = r_done;
   assign ma_timeout = r_timeout;
   assign bus_sel    = r_sel;
   assign bus_rd     = r_rd;
   assign bus_wr     = r_wr;
   assign bus_addr   = r_addr;
   assign bus_wdata  = r_wdata;
   assign bus_be     = r_be;

endmodule : mem_bus_ctrl
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_ctrl
//  Description : Self-checking bench for mem_bus_ctrl with a behavioural
//                region/latency/lane model and a reactive slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ma_addr;
   logic [31:0] ma_data_out;
   logic [3:0]  ma_data_mask;
   logic        ma_rd_req;
   logic        ma_wr_req;
   logic [31:0] ma_data_in;
   logic        ma_done;
   logic        ma_timeout;
   logic [2:0]  bus_sel;
   logic        bus_rd;
   logic        bus_wr;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic [31:0] bus_rdata0;
   logic [31:0] bus_rdata1;
   logic [31:0] bus_rdata2;
   logic [2:0]  bus_ack;

   int checks = 0;
   int errors = 0;

   // Observations from the last transaction
   int          obs_done_cycle;
   int          obs_done_count;
   int          obs_strobes;
   logic        obs_timeout;
   logic [31:0] obs_data_in;
   logic [2:0]  obs_sel;
   logic        obs_rd;
   logic        obs_wr;
   logic [31:0] obs_addr;
   logic [31:0] obs_wdata;
   logic [3:0]  obs_be;
   bit          obs_unstable;
   bit          obs_to_outside;

   // Model state: last completed read value
   logic [31:0] exp_data_in;

   mem_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .ma_addr      (ma_addr),
      .ma_data_out  (ma_data_out),
      .ma_data_mask (ma_data_mask),
      .ma_rd_req    (ma_rd_req),
      .ma_wr_req    (ma_wr_req),
      .ma_data_in   (ma_data_in),
      .ma_done      (ma_done),
      .ma_timeout   (ma_timeout),
      .bus_sel      (bus_sel),
      .bus_rd       (bus_rd),
      .bus_wr       (bus_wr),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_be       (bus_be),
      .bus_rdata0   (bus_rdata0),
      .bus_rdata1   (bus_rdata1),
      .bus_rdata2   (bus_rdata2),
      .bus_ack      (bus_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Reference model: memory map as address ranges
   // ------------------------------------------------------------------
   function automatic logic [2:0] exp_region(input logic [31:0] a);
      if (a < 32'h0000_4000)                              return 3'b001;
      if (a >= 32'h4000_0000 && a < 32'h4001_0000)        return 3'b010;
      if (a >= 32'h8000_0000 && a < 32'h8000_1000)        return 3'b100;
      return 3'b000;
   endfunction

   function automatic logic [3:0] exp_be(input logic [3:0] m, input int off);
      int v;
      v = int'(m) * (2 ** off);
      return 4'(v % 16);
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [31:0] d, input int off);
      longint v;
      v = longint'(d) * (longint'(256) ** off);
      return 32'(v % 64'h1_0000_0000);
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [31:0] d, input int off);
      return d / (32'd256 ** off);
   endfunction

   // ------------------------------------------------------------------
   // Driver/monitor: issue one request, act as slave, record what happens.
   // Cycle 1 is the first cycle after the edge that sees the request.
   // ack_k: ack in that ACCESS cycle (0 = never). noise: random acks on
   // other regions. scramble: change ma_* while the request is in flight.
   // ------------------------------------------------------------------
   task automatic do_txn(input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] mask, input logic rd, input logic wr,
                         input int ack_k, input logic [31:0] rd0,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input bit noise, input bit scramble);
      logic [2:0] slave_sel;
      slave_sel = exp_region(addr);
      @(posedge clk); #1;
      ma_addr = addr; ma_data_out = wd; ma_data_mask = mask;
      ma_rd_req = rd; ma_wr_req = wr;
      bus_rdata0 = rd0; bus_rdata1 = rd1; bus_rdata2 = rd2;
      bus_ack = 3'b000;
      obs_done_cycle = -1; obs_done_count = 0; obs_strobes = 0;
      obs_timeout = 1'b0; obs_data_in = '0; obs_unstable = 0;
      obs_to_outside = 0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            obs_sel = bus_sel; obs_rd = bus_rd; obs_wr = bus_wr;
            obs_addr = bus_addr; obs_wdata = bus_wdata; obs_be = bus_be;
         end
         if (bus_rd || bus_wr) begin
            obs_strobes++;
            if (bus_sel !== obs_sel || bus_addr !== obs_addr ||
                bus_wdata !== obs_wdata || bus_be !== obs_be ||
                bus_rd !== obs_rd || bus_wr !== obs_wr)
               obs_unstable = 1;
         end
         if (ma_timeout && !ma_done) obs_to_outside = 1;
         if (ma_done) begin
            obs_done_count++;
            if (obs_done_cycle < 0) begin
               obs_done_cycle = c;
               obs_timeout    = ma_timeout;
               obs_data_in    = ma_data_in;
               ma_rd_req = 1'b0;
               ma_wr_req = 1'b0;
            end
         end
         if (obs_done_cycle < 0) begin
            bus_ack = (c == ack_k) ? slave_sel : 3'b000;
            if (noise) bus_ack = bus_ack | (3'($urandom) & ~slave_sel);
            if (scramble) begin
               ma_addr = $urandom; ma_data_out = $urandom;
               ma_data_mask = 4'($urandom);
            end
         end else begin
            bus_ack = 3'b000;
         end
      end
      bus_ack = 3'b000;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      ma_addr = '0; ma_data_out = '0; ma_data_mask = '0;
      ma_rd_req = 1'b0; ma_wr_req = 1'b0;
      bus_rdata0 = '0; bus_rdata1 = '0; bus_rdata2 = '0; bus_ack = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ma_done, ma_timeout, bus_rd, bus_wr} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000",
                  {ma_done, ma_timeout, bus_rd, bus_wr});
      end
      checks++;
      if (bus_sel !== 3'b000 || bus_be !== 4'b0000) begin
         errors++;
         $display("FAIL reset_sel_be: got sel=%b be=%b expected 000/0000", bus_sel, bus_be);
      end
      checks++;
      if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || ma_data_in !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h wdata=%h din=%h expected all zero",
                  bus_addr, bus_wdata, ma_data_in);
      end
      exp_data_in = 32'h0;
      rst = 1'b0;
   endtask

   task automatic test_word_read();
      do_txn(32'h4000_0010, 32'h0, 4'b1111, 1'b1, 1'b0, 1,
             32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 0, 0);
      checks++;
      if (obs_sel !== 3'b010 || obs_rd !== 1'b1 || obs_wr !== 1'b0 || obs_be !== 4'b1111) begin
         errors++;
         $display("FAIL word_read_bus: got sel=%b rd=%b wr=%b be=%b expected 010/1/0/1111",
                  obs_sel, obs_rd, obs_wr, obs_be);
      end
      checks++;
      if (obs_done_cycle !== 2 || obs_timeout !== 1'b0) begin
         errors++;
         $display("FAIL word_read_done: got cycle=%0d to=%b expected 2/0",
                  obs_done_cycle, obs_timeout);
      end
      checks++;
      if (obs_data_in !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL word_read_data: got %h expected deadbeef", obs_data_in);
      end
      exp_data_in = 32'hDEAD_BEEF;
   endtask

   task automatic test_byte_store();
      do_txn(32'h8000_0003, 32'h0000_00AB, 4'b0001, 1'b0, 1'b1, 1,
             32'h0, 32'h0, 32'h0, 0, 0);
      checks++;
      if (obs_sel !== 3'b100 || obs_wr !== 1'b1 || obs_rd !== 1'b0) begin
         errors++;
         $display("FAIL byte_store_sel: got sel=%b wr=%b rd=%b expected 100/1/0",
                  obs_sel, obs_wr, obs_rd);
      end
      checks++;
      if (obs_addr !== 32'h8000_0000 || obs_be !== 4'b1000 || obs_wdata !== 32'hAB00_0000) begin
         errors++;
         $display("FAIL byte_store_lanes: got addr=%h be=%b wdata=%h expected 80000000/1000/ab000000",
                  obs_addr, obs_be, obs_wdata);
      end
      checks++;
      if (obs_done_cycle !== 2 || obs_timeout !== 1'b0 || obs_data_in !== exp_data_in) begin
         errors++;
         $display("FAIL byte_store_done: got cycle=%0d to=%b din=%h expected 2/0/%h",
                  obs_done_cycle, obs_timeout, obs_data_in, exp_data_in);
      end
   endtask

   task automatic test_half_load();
      do_txn(32'h0000_0002, 32'h0, 4'b0011, 1'b1, 1'b0, 2,
             32'h1234_5678, 32'h0, 32'h0, 0, 0);
      checks++;
      if (obs_sel !== 3'b001 || obs_be !== 4'b1100 || obs_addr !== 32'h0) begin
         errors++;
         $display("FAIL half_load_bus: got sel=%b be=%b addr=%h expected 001/1100/0",
                  obs_sel, obs_be, obs_addr);
      end
      checks++;
      if (obs_done_cycle !== 3 || obs_data_in !== 32'h0000_1234) begin
         errors++;
         $display("FAIL half_load_data: got cycle=%0d din=%h expected 3/00001234",
                  obs_done_cycle, obs_data_in);
      end
      exp_data_in = 32'h0000_1234;
   endtask

   task automatic test_faults();
      // Store into ROM
      do_txn(32'h0000_0100, 32'h5555_5555, 4'b1111, 1'b0, 1'b1, 1,
             32'h0, 32'h0, 32'h0, 0, 0);
      checks++;
      if (obs_strobes !== 0 || obs_sel !== 3'b000) begin
         errors++;
         $display("FAIL rom_write_strobe: got strobes=%0d sel=%b expected 0/000",
                  obs_strobes, obs_sel);
      end
      checks++;
      if (obs_done_cycle !== 2 || obs_timeout !== 1'b1 || obs_done_count !== 1) begin
         errors++;
         $display("FAIL rom_write_done: got cycle=%0d to=%b pulses=%0d expected 2/1/1",
                  obs_done_cycle, obs_timeout, obs_done_count);
      end
      // Unmapped read; slave noise on every region must be ignored
      do_txn(32'hC000_0000, 32'h0, 4'b1111, 1'b1, 1'b0, 1,
             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
      checks++;
      if (obs_strobes !== 0 || obs_done_cycle !== 2 || obs_timeout !== 1'b1) begin
         errors++;
         $display("FAIL unmapped_read: got strobes=%0d cycle=%0d to=%b expected 0/2/1",
                  obs_strobes, obs_done_cycle, obs_timeout);
      end
      checks++;
      if (obs_data_in !== exp_data_in) begin
         errors++;
         $display("FAIL unmapped_hold: got din=%h expected %h", obs_data_in, exp_data_in);
      end
   endtask

   task automatic test_timeout();
      // No ack at all
      do_txn(32'h4000_0100, 32'h0, 4'b1111, 1'b1, 1'b0, 0,
             32'h0, 32'hCAFE_F00D, 32'h0, 0, 0);
      checks++;
      if (obs_strobes !== TO || obs_done_cycle !== TO + 1 || obs_timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout: got strobes=%0d cycle=%0d to=%b expected %0d/%0d/1",
                  obs_strobes, obs_done_cycle, obs_timeout, TO, TO + 1);
      end
      checks++;
      if (obs_data_in !== exp_data_in) begin
         errors++;
         $display("FAIL timeout_hold: got din=%h expected %h", obs_data_in, exp_data_in);
      end
      // Ack in the very last allowed cycle still succeeds
      do_txn(32'h4000_0104, 32'h0, 4'b1111, 1'b1, 1'b0, TO,
             32'h0, 32'hCAFE_F00D, 32'h0, 0, 0);
      checks++;
      if (obs_done_cycle !== TO + 1 || obs_timeout !== 1'b0 || obs_data_in !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL ack_at_limit: got cycle=%0d to=%b din=%h expected %0d/0/cafef00d",
                  obs_done_cycle, obs_timeout, obs_data_in, TO + 1);
      end
      exp_data_in = 32'hCAFE_F00D;
   endtask

   task automatic test_reset_mid();
      bit done_seen;
      bit strobe_seen;
      @(posedge clk); #1;
      ma_addr = 32'h4000_0020; ma_data_mask = 4'b1111; ma_rd_req = 1'b1;
      bus_ack = 3'b000;
      @(posedge clk); #1;
      checks++;
      if (bus_rd !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_start: got bus_rd=%b expected 1", bus_rd);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus_rd, bus_wr, bus_sel, ma_done} !== 6'b0) begin
         errors++;
         $display("FAIL rst_mid_idle: got rd=%b wr=%b sel=%b done=%b expected all 0",
                  bus_rd, bus_wr, bus_sel, ma_done);
      end
      rst = 1'b0;
      ma_rd_req = 1'b0;
      done_seen = 0; strobe_seen = 0;
      repeat (TO + 3) begin
         @(posedge clk); #1;
         if (ma_done) done_seen = 1;
         if (bus_rd || bus_wr) strobe_seen = 1;
      end
      checks++;
      if (done_seen || strobe_seen) begin
         errors++;
         $display("FAIL rst_mid_no_done: got done=%b strobe=%b expected 0/0",
                  done_seen, strobe_seen);
      end
      exp_data_in = 32'h0;
   endtask

   task automatic test_random();
      logic [31:0] addr, wd, rd0, rd1, rd2, rdv;
      logic [3:0]  mask;
      logic        rd, wr;
      logic [2:0]  reg_oh;
      int          kind, size, off, ack_k, e_done, e_strobes;
      bit          fault, e_to, acked;
      logic [31:0] unmapped [5] = '{32'h0000_4000, 32'h4001_0000, 32'h8000_1000,
                                   32'h3FFF_FFFC, 32'hC000_0000};
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0:       addr = 32'($urandom_range(0, 16383));
            1:       addr = 32'h4000_0000 + 32'($urandom_range(0, 65535));
            2:       addr = 32'h8000_0000 + 32'($urandom_range(0, 4095));
            default: addr = unmapped[$urandom_range(0, 4)] + 32'($urandom_range(0, 3));
         endcase
         size = $urandom_range(0, 2);
         off  = (size == 0) ? $urandom_range(0, 3) : (size == 1) ? 2 * $urandom_range(0, 1) : 0;
         addr = {addr[31:2], 2'(off)};
         mask = (size == 0) ? 4'b0001 : (size == 1) ? 4'b0011 : 4'b1111;
         case ($urandom_range(0, 2))
            0:       begin rd = 1'b1; wr = 1'b0; end
            1:       begin rd = 1'b0; wr = 1'b1; end
            default: begin rd = 1'b1; wr = 1'b1; end
         endcase
         wd = $urandom; rd0 = $urandom; rd1 = $urandom; rd2 = $urandom;
         ack_k = $urandom_range(0, TO + 1);
         do_txn(addr, wd, mask, rd, wr, ack_k, rd0, rd1, rd2, 1, 1);

         reg_oh = exp_region(addr);
         fault  = (reg_oh == 3'b000) || (!rd && reg_oh == 3'b001);
         acked  = (ack_k >= 1 && ack_k <= TO);
         if (fault) begin
            e_done = 2; e_to = 1; e_strobes = 0;
         end else if (acked) begin
            e_done = 1 + ack_k; e_to = 0; e_strobes = ack_k;
         end else begin
            e_done = 1 + TO; e_to = 1; e_strobes = TO;
         end
         if (!fault && acked && rd) begin
            rdv = (reg_oh == 3'b001) ? rd0 : (reg_oh == 3'b010) ? rd1 : rd2;
            exp_data_in = exp_rdata(rdv, off);
         end

         checks++;
         if (obs_done_cycle !== e_done || obs_timeout !== e_to || obs_done_count !== 1) begin
            errors++;
            $display("FAIL rnd%0d_done addr=%h: got cycle=%0d to=%b pulses=%0d expected %0d/%b/1",
                     n, addr, obs_done_cycle, obs_timeout, obs_done_count, e_done, e_to);
         end
         checks++;
         if (obs_strobes !== e_strobes || obs_to_outside) begin
            errors++;
            $display("FAIL rnd%0d_strobes addr=%h: got strobes=%0d stray_to=%0d expected %0d/0",
                     n, addr, obs_strobes, obs_to_outside, e_strobes);
         end
         checks++;
         if (obs_data_in !== exp_data_in) begin
            errors++;
            $display("FAIL rnd%0d_data addr=%h: got %h expected %h",
                     n, addr, obs_data_in, exp_data_in);
         end
         checks++;
         if (obs_sel !== (fault ? 3'b000 : reg_oh)) begin
            errors++;
            $display("FAIL rnd%0d_sel addr=%h: got %b expected %b",
                     n, addr, obs_sel, fault ? 3'b000 : reg_oh);
         end
         if (!fault) begin
            checks++;
            if (obs_addr !== {addr[31:2], 2'b00} || obs_be !== exp_be(mask, off) ||
                obs_wdata !== exp_wdata(wd, off) || obs_rd !== rd || obs_wr !== !rd ||
                obs_unstable) begin
               errors++;
               $display("FAIL rnd%0d_bus: got addr=%h be=%b wdata=%h rd=%b wr=%b unstable=%0d expected %h/%b/%h/%b/%b/0",
                        n, obs_addr, obs_be, obs_wdata, obs_rd, obs_wr, obs_unstable,
                        {addr[31:2], 2'b00}, exp_be(mask, off), exp_wdata(wd, off), rd, !rd);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_word_read();
      test_byte_store();
      test_half_load();
      test_faults();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_bus_ctrl
`default_nettype wire

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Memory-side controller behind the CPU's `ma_*` access port. It accepts one read or write request at a time and decodes the address into one of three regions (ROM, RAM, IO). It places the data on the correct byte lanes of a word-wide slave bus and returns the result with a one-cycle `ma_done` pulse. Unmapped addresses, ROM writes and slaves that never acknowledge are all reported as `ma_timeout`, which the CPU turns into access faults.

## Interface
Parameters:
- ROM_BASE, 32'h0000_0000, region 0 base; region is read-only
- ROM_SIZE_BITS, 14, region 0 spans 2^ROM_SIZE_BITS bytes
- RAM_BASE, 32'h4000_0000, region 1 base
- RAM_SIZE_BITS, 16, region 1 size exponent
- IO_BASE, 32'h8000_0000, region 2 base
- IO_SIZE_BITS, 12, region 2 size exponent
- TIMEOUT_CYCLES, 255, number of ACCESS cycles without ack before a timeout is reported (1..255)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ma_addr  in  32  byte address from the CPU
- ma_data_out  in  32  store data from the CPU, low-aligned
- ma_data_mask  in  4  low-aligned lane mask: 0001, 0011 or 1111
- ma_rd_req, ma_wr_req  in  1  request levels, held until `ma_done`
- ma_data_in  out  32  read data, shifted down to bit 0
- ma_done  out  1  one-cycle completion pulse
- ma_timeout  out  1  fault flag, valid only with `ma_done`
- bus_sel  out  3  one-hot region select (bit 0 ROM, bit 1 RAM, bit 2 IO)
- bus_rd, bus_wr  out  1  slave strobes, held until ack or timeout
- bus_addr  out  32  word address: {ma_addr[31:2], 2'b00}
- bus_wdata  out  32  lane-shifted store data
- bus_be  out  4  lane-shifted byte enables
- bus_rdata0, bus_rdata1, bus_rdata2  in  32  per-region read data
- bus_ack  in  3  per-region acknowledge

## Operation
- States: IDLE, ACCESS, FAULT, DONE.
- **IDLE**
  - Waits for `ma_rd_req | ma_wr_req`. If both are high, the read wins.
  - Region hit rule: `ma_addr[31:N] == BASE[31:N]`, where N is that region's SIZE_BITS.
  - No hit, or a write hitting ROM: go to FAULT.
  - Otherwise register the select, strobe, address, `bus_wdata = ma_data_out << (8*ma_addr[1:0])` and `bus_be = (ma_data_mask << ma_addr[1:0])[3:0]`, clear the counter, and go to ACCESS.
- **ACCESS**
  - Strobes and bus signals are held stable. The counter increments each cycle.
  - When `bus_ack[sel]` is seen: for a read, latch `bus_rdataX >> (8*offset)` into `ma_data_in`; clear `ma_timeout`; go to DONE.
  - If the counter reaches TIMEOUT_CYCLES with no ack: set `ma_timeout`; go to DONE.
  - Ack bits of non-selected regions are ignored.
- **FAULT**: set `ma_timeout`, go to DONE. No bus strobe is ever issued.
- **DONE**
  - Strobes and `bus_sel` are low; `ma_done` = 1 for exactly this cycle; go to IDLE.
  - The CPU drops its request on this edge, so no request is re-accepted.
- `ma_data_in` holds its last value until the next read completes. `ma_timeout` remains 0 outside DONE.
- Lane checking is not done here; the CPU rejects misaligned accesses before issuing them. Bits shifted past lane 3 are dropped.

## Timing
- Reset values: state IDLE; `ma_done`, `ma_timeout`, `bus_rd`, `bus_wr` = 0; `bus_sel` = 000; `bus_be` = 0000; `bus_addr`, `bus_wdata`, `ma_data_in` = 0.
- All outputs are registered.
- Latency, with the request first seen at edge T:
  - Strobes are visible from cycle T+1.
  - If ack arrives in the k-th ACCESS cycle (k ≥ 1), `ma_done` is high in cycle T+1+k.
  - Minimum latency is 2 cycles.
- Fault latency: `ma_done` is high in cycle T+2.
- Timeout latency: `ma_done` is high in cycle T+1+TIMEOUT_CYCLES.
- An ack arriving on the same edge the counter hits the limit counts as success.
- Reset during an operation: the next cycle is IDLE with strobes low, and no `ma_done` is issued.
- A request is accepted only in IDLE. Changes on `ma_*` during ACCESS are ignored.

## Structure
- Package `mem_bus_pkg`: state encoding, region index constants (`REGION_ROM` = 0, `REGION_RAM` = 1, `REGION_IO` = 2), and the lane-shift width constant.
- Sub-module `mem_bus_region_decoder`: combinational. Takes the address and the write flag; produces the one-hot `hit[2:0]` and `illegal`. It is instantiated once.

## Test plan
- Word read from RAM at 0x4000_0010, slave acks on the first ACCESS cycle with 0xDEADBEEF → `bus_be` = 1111, `ma_done` 2 cycles after the request with `ma_timeout` = 0, `ma_data_in` = 0xDEADBEEF.
- Byte store of 0x000000AB (mask 0001) to 0x8000_0003 → `bus_sel` = 100, `bus_addr` = 0x8000_0000, `bus_be` = 1000, `bus_wdata` = 0xAB000000.
- Half load from ROM at 0x0000_0002, slave returns 0x12345678 → `ma_data_in` = 0x00001234.
- Store to 0x0000_0100 (ROM), and separately a read of 0xC000_0000 (unmapped) → no strobe issued; `ma_done` and `ma_timeout` high 2 cycles after the request.
- RAM read with the ack withheld and TIMEOUT_CYCLES = 4 → `bus_rd` high for 4 cycles, then `ma_done` = `ma_timeout` = 1.
- `rst` asserted in the second ACCESS cycle → the next cycle shows IDLE with strobes at 0, and no `ma_done` pulse.
